// File: rtl/spmv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spmv_pkg
//  Brief    : Shared widths, FIFO entry layout and FSM state type for the
//             SpMV row accumulator.
//  Revision : 1.0  initial release
// ============================================================================
package spmv_pkg;

    localparam int VAL_W_DEF = 16;
    localparam int COL_W_DEF = 10;
    localparam int ROW_W_DEF = 10;
    localparam int ACC_W_DEF = 40;

    // Layout of one nonzero entry as stored in the upstream FIFO (MSB first).
    typedef struct packed {
        logic                        row_last;
        logic [COL_W_DEF-1:0]        col_idx;
        logic signed [VAL_W_DEF-1:0] value;
    } nz_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    // Width of one FIFO entry; also used to size the FIFO DATA_WIDTH.
    function automatic int entry_width(input int col_w, input int val_w);
        return 1 + col_w + val_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spmv_mac.sv
`default_nettype none
// ============================================================================
//  Module   : spmv_mac
//  Brief    : Registered multiply-accumulate stage. Accumulates value*x per
//             row and loads the row sum into y_data on the row_last entry.
//             SPMV_ACC_SAT_EN: saturate every accumulate and add sat_flag.
//  Revision : 1.0  initial release
// ============================================================================
module spmv_mac #(
    parameter int VAL_W = 16,
    parameter int ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    row_last,
    input  logic signed [VAL_W-1:0] value,
    input  logic signed [VAL_W-1:0] x_data,
    output logic [ACC_W-1:0]        y_data
`ifdef SPMV_ACC_SAT_EN
    ,
    output logic                    sat_flag
`endif
);

    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]          y_data_q, y_data_d;
    logic signed [2*VAL_W-1:0] product;
    logic [ACC_W-1:0]          sum_res;

`ifdef SPMV_ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;
    logic                  overflow;
    logic                  sat_flag_q, sat_flag_d;

    // Full product, one guard bit on the sum, clamp when the guard disagrees.
    always_comb begin
        product  = (2*VAL_W)'(value) * (2*VAL_W)'(x_data);
        sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(product);
        overflow = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        if (overflow)
            sum_res = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            sum_res = sum_wide[ACC_W-1:0];
    end
`else
    // Full product, two's-complement wrap at ACC_W.
    always_comb begin
        product = (2*VAL_W)'(value) * (2*VAL_W)'(x_data);
        sum_res = acc_q + ACC_W'(product);
    end
`endif

    // Accumulate non-last entries; emit and restart on the row_last entry.
    always_comb begin
        acc_d    = acc_q;
        y_data_d = y_data_q;
`ifdef SPMV_ACC_SAT_EN
        sat_flag_d = sat_flag_q;
`endif
        if (clear) begin
            acc_d = '0;
`ifdef SPMV_ACC_SAT_EN
            sat_flag_d = 1'b0;
`endif
        end else if (en) begin
            if (row_last) begin
                y_data_d = sum_res;
                acc_d    = '0;
            end else begin
                acc_d = sum_res;
            end
`ifdef SPMV_ACC_SAT_EN
            if (overflow)
                sat_flag_d = 1'b1;
`endif
        end
    end

    // Accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            y_data_q <= '0;
`ifdef SPMV_ACC_SAT_EN
            sat_flag_q <= 1'b0;
`endif
        end else begin
            acc_q    <= acc_d;
            y_data_q <= y_data_d;
`ifdef SPMV_ACC_SAT_EN
            sat_flag_q <= sat_flag_d;
`endif
        end
    end

    assign y_data = y_data_q;
`ifdef SPMV_ACC_SAT_EN
    assign sat_flag = sat_flag_q;
`endif

endmodule
`default_nettype wire

// File: rtl/spmv_row_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : spmv_row_accumulator
//  Brief    : Pops CSR nonzeros from the entry FIFO, fetches x[col_idx],
//             multiply-accumulates per row and emits y[row] over valid/ready.
//             Start/done FSM, one matrix pass per start.
//             Optional macro SPMV_ACC_SAT_EN: saturating accumulate, sat_flag.
//  Revision : 1.0  initial release
// ============================================================================
module spmv_row_accumulator
    import spmv_pkg::*;
#(
    parameter int VAL_W = VAL_W_DEF,
    parameter int COL_W = COL_W_DEF,
    parameter int ROW_W = ROW_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ROW_W-1:0]       num_rows,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [COL_W+VAL_W:0]   fifo_data,
    output logic                   x_rd_en,
    output logic [COL_W-1:0]       x_addr,
    input  logic [VAL_W-1:0]       x_data,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic [ACC_W-1:0]       y_data,
    output logic [ROW_W-1:0]       y_row,
    output logic                   busy,
    output logic                   done
`ifdef SPMV_ACC_SAT_EN
    ,
    output logic                   sat_flag
`endif
);

    localparam int ENTRY_W = entry_width(COL_W, VAL_W);

    acc_state_t              state_q, state_d;
    logic [ROW_W-1:0]        num_rows_q, num_rows_d;
    logic [ROW_W-1:0]        row_cnt_q, row_cnt_d;
    logic                    s1_valid_q, s1_valid_d;
    logic                    s2_valid_q, s2_valid_d;
    logic                    s2_last_q, s2_last_d;
    logic signed [VAL_W-1:0] s2_value_q, s2_value_d;
    logic                    y_valid_q, y_valid_d;
    logic [ROW_W-1:0]        y_row_q, y_row_d;

    logic [ENTRY_W-1:0]      s1_entry;
    logic                    adv;
    logic                    start_ok;
    logic                    s1_last_hit;
    logic                    s2_last_hit;
    logic [ROW_W+1:0]        pending_rows;
    logic                    exhausted;
    logic [ROW_W-1:0]        last_row;
    logic                    mac_en;

    assign s1_entry = fifo_data;

    // Pipeline advance, pop gating and the rows-already-claimed count.
    always_comb begin
        adv          = !(y_valid_q && !y_ready);
        start_ok     = start && (state_q != RUN);
        s1_last_hit  = s1_valid_q && s1_entry[COL_W+VAL_W];
        s2_last_hit  = s2_valid_q && s2_last_q;
        // Row_last entries still in flight count as finished rows so the
        // pass stops popping before touching the next pass's entries.
        pending_rows = (ROW_W+2)'(row_cnt_q) + (ROW_W+2)'(s1_last_hit)
                     + (ROW_W+2)'(s2_last_hit);
        exhausted    = pending_rows >= (ROW_W+2)'(num_rows_q);
        last_row     = num_rows_q - ROW_W'(1);
        fifo_rd_en   = (state_q == RUN) && !fifo_empty && adv && !exhausted;
        x_rd_en      = s1_valid_q && adv;
        x_addr       = s1_valid_q ? s1_entry[COL_W+VAL_W-1:VAL_W] : '0;
        mac_en       = adv && s2_valid_q;
    end

    // Next state for the FSM, pipeline valids and result handshake.
    always_comb begin
        state_d    = state_q;
        num_rows_d = num_rows_q;
        row_cnt_d  = row_cnt_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_value_d = s2_value_q;
        y_valid_d  = y_valid_q;
        y_row_d    = y_row_q;

        case (state_q)
            IDLE, DONE: begin
                if (start)
                    state_d = (num_rows == '0) ? DONE : RUN;
            end
            RUN: begin
                if (y_valid_q && y_ready && (y_row_q == last_row))
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            s1_valid_d = fifo_rd_en;
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_entry[COL_W+VAL_W];
            s2_value_d = s1_entry[VAL_W-1:0];
        end

        // Retire the presented result; a new one may load in the same cycle.
        if (y_valid_q && y_ready)
            y_valid_d = 1'b0;
        if (adv && s2_last_hit) begin
            y_valid_d = 1'b1;
            y_row_d   = row_cnt_q;
            row_cnt_d = row_cnt_q + ROW_W'(1);
        end

        if (start_ok) begin
            num_rows_d = num_rows;
            row_cnt_d  = '0;
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            y_valid_d  = 1'b0;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            num_rows_q <= '0;
            row_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_value_q <= '0;
            y_valid_q  <= 1'b0;
            y_row_q    <= '0;
        end else begin
            state_q    <= state_d;
            num_rows_q <= num_rows_d;
            row_cnt_q  <= row_cnt_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_value_q <= s2_value_d;
            y_valid_q  <= y_valid_d;
            y_row_q    <= y_row_d;
        end
    end

    spmv_mac #(
        .VAL_W (VAL_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .en       (mac_en),
        .row_last (s2_last_q),
        .value    (s2_value_q),
        .x_data   (x_data),
        .y_data   (y_data)
`ifdef SPMV_ACC_SAT_EN
        ,
        .sat_flag (sat_flag)
`endif
    );

    assign y_valid = y_valid_q;
    assign y_row   = y_row_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_spmv_row_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spmv_row_accumulator
//  Brief    : Scoreboard bench for spmv_row_accumulator with a FIFO model and
//             a synchronous-read x memory model. ACC_W=32.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spmv_row_accumulator;

    localparam int VAL_W = 16;
    localparam int COL_W = 10;
    localparam int ROW_W = 10;
    localparam int ACC_W = 32;
    localparam int EW    = 1 + COL_W + VAL_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [ROW_W-1:0] num_rows = '0;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [EW-1:0]    fifo_data = '0;
    logic             x_rd_en;
    logic [COL_W-1:0] x_addr;
    logic [VAL_W-1:0] x_data = '0;
    logic             y_valid;
    logic             y_ready = 1'b1;
    logic [ACC_W-1:0] y_data;
    logic [ROW_W-1:0] y_row;
    logic             busy;
    logic             done;
`ifdef SPMV_ACC_SAT_EN
    logic             sat_flag;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int done_cyc = 0;

    logic [EW-1:0]    fifo_mem [0:63];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    logic [VAL_W-1:0] xmem [0:(1<<COL_W)-1];

    logic [ACC_W-1:0] exp_data_q [$];
    logic [ROW_W-1:0] exp_row_q [$];

    spmv_row_accumulator #(
        .VAL_W (VAL_W),
        .COL_W (COL_W),
        .ROW_W (ROW_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_rows   (num_rows),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .x_rd_en    (x_rd_en),
        .x_addr     (x_addr),
        .x_data     (x_data),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .y_data     (y_data),
        .y_row      (y_row),
        .busy       (busy),
        .done       (done)
`ifdef SPMV_ACC_SAT_EN
        ,
        .sat_flag   (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO model: data appears the cycle after a pop; reset with the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= 0;
            fifo_data <= '0;
        end else if (fifo_rd_en) begin
            fifo_data <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // x memory model: synchronous read, output holds while not enabled.
    always @(posedge clk) begin
        if (x_rd_en)
            x_data <= xmem[x_addr];
    end

    task automatic check_value(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_entry(input logic last, input int col, input int val);
        fifo_mem[wr_ptr] = {last, COL_W'(col), VAL_W'(val)};
        wr_ptr++;
    endtask

    task automatic expect_row(input int row, input longint val);
        exp_row_q.push_back(ROW_W'(row));
        exp_data_q.push_back(ACC_W'(val));
    endtask

    task automatic start_pass(input int n);
        @(posedge clk); #1;
        num_rows = ROW_W'(n);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cnt = 0;
        @(negedge clk);
        while (!done && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check_value(tag, 64'(done), 64'd1);
        done_cyc = cyc;
    endtask

    // Scoreboard: compare every accepted result against the queued model.
    always @(negedge clk) begin
        if (!rst && y_valid && y_ready) begin
            last_hs_cyc = cyc;
            if (exp_data_q.size() == 0) begin
                check_value("sb_unexpected_result", 64'd1, 64'd0);
            end else begin
                check_value("y_data", 64'(y_data), 64'(exp_data_q.pop_front()));
                check_value("y_row", 64'(y_row), 64'(exp_row_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << COL_W); i++) xmem[i] = '0;
        xmem[0] = 16'sd7;
        xmem[1] = 16'sd10;
        xmem[2] = 16'sd32767;
        xmem[4] = 16'sd6;

        // Reset state
        repeat (3) @(negedge clk);
        check_value("rst_y_valid", 64'(y_valid), 64'd0);
        check_value("rst_busy", 64'(busy), 64'd0);
        check_value("rst_done", 64'(done), 64'd0);
        check_value("rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
        check_value("rst_x_rd_en", 64'(x_rd_en), 64'd0);
        check_value("rst_y_data", 64'(y_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic two-row pass: y0 = 3*10 + -2*6 = 18, y1 = 5*7 = 35
        push_entry(1'b0, 1, 3);
        push_entry(1'b1, 4, -2);
        push_entry(1'b1, 0, 5);
        expect_row(0, 18);
        expect_row(1, 35);
        start_pass(2);
        check_value("busy_run", 64'(busy), 64'd1);
        wait_done("t1_done");
        check_value("t1_done_latency", 64'(done_cyc - last_hs_cyc), 64'd1);
        check_value("t1_fifo_drained", 64'(fifo_empty), 64'd1);
`ifdef SPMV_ACC_SAT_EN
        check_value("t1_sat_flag", 64'(sat_flag), 64'd0);
`endif

        // Same stream with 5 cycles of backpressure on the first result
        push_entry(1'b0, 1, 3);
        push_entry(1'b1, 4, -2);
        push_entry(1'b1, 0, 5);
        expect_row(0, 18);
        expect_row(1, 35);
        y_ready = 1'b0;
        start_pass(2);
        begin
            int cnt = 0;
            @(negedge clk);
            while (!y_valid && cnt < 50) begin
                @(negedge clk);
                cnt++;
            end
            check_value("t2_y_valid_seen", 64'(y_valid), 64'd1);
        end
        for (int i = 0; i < 5; i++) begin
            check_value("t2_stall_y_data", 64'(y_data), 64'd18);
            check_value("t2_stall_rd_en", 64'({fifo_rd_en, x_rd_en}), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        y_ready = 1'b1;
        wait_done("t2_done");

        // Empty row in the middle: y = 20, 0, -6+28=22
        push_entry(1'b1, 1, 2);
        push_entry(1'b1, 0, 0);
        push_entry(1'b0, 4, -1);
        push_entry(1'b1, 0, 4);
        expect_row(0, 20);
        expect_row(1, 0);
        expect_row(2, 22);
        start_pass(3);
        wait_done("t3_done");

        // One row requested with more entries queued behind it
        push_entry(1'b1, 0, 1);
        push_entry(1'b0, 1, 9);
        push_entry(1'b1, 1, 9);
        expect_row(0, 7);
        start_pass(1);
        wait_done("t4_done");
        repeat (3) @(negedge clk);
        check_value("t4_fifo_not_empty", 64'(fifo_empty), 64'd0);
        check_value("t4_entries_left", 64'(wr_ptr - rd_ptr), 64'd2);
        // The leftover entries form the next pass: 9*10 + 9*10 = 180
        expect_row(0, 180);
        start_pass(1);
        wait_done("t4b_done");

        // Zero rows: straight to DONE, nothing popped
        start_pass(0);
        @(negedge clk);
        check_value("t5_zero_done", 64'(done), 64'd1);
        check_value("t5_zero_busy", 64'(busy), 64'd0);

        // Overflow: 4 * 32767^2 = 4294705156 at ACC_W=32
        for (int i = 0; i < 3; i++) push_entry(1'b0, 2, 32767);
        push_entry(1'b1, 2, 32767);
`ifdef SPMV_ACC_SAT_EN
        expect_row(0, 64'sd2147483647);
`else
        expect_row(0, -64'sd262140);
`endif
        start_pass(1);
        wait_done("t6_done");
`ifdef SPMV_ACC_SAT_EN
        check_value("t6_sat_flag", 64'(sat_flag), 64'd1);
`endif

        // Asynchronous reset mid-row, then a clean pass
        push_entry(1'b0, 1, 3);
        push_entry(1'b1, 4, -2);
        start_pass(1);
        #3;
        rst = 1'b1;
        #1;
        check_value("t7_rst_busy", 64'(busy), 64'd0);
        check_value("t7_rst_y_valid", 64'(y_valid), 64'd0);
        check_value("t7_rst_y_data", 64'(y_data), 64'd0);
        check_value("t7_rst_rd_en", 64'({fifo_rd_en, x_rd_en}), 64'd0);
        check_value("t7_rst_done", 64'(done), 64'd0);
`ifdef SPMV_ACC_SAT_EN
        check_value("t7_rst_sat_flag", 64'(sat_flag), 64'd0);
`endif
        wr_ptr = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        push_entry(1'b0, 1, 3);
        push_entry(1'b1, 4, -2);
        expect_row(0, 18);
        start_pass(1);
        wait_done("t7_done");

        repeat (2) @(negedge clk);
        check_value("sb_drained", 64'(exp_data_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
